// File: rtl/ising_seq_pkg.sv
// Shared constants, state encoding and address helpers for the ising_axi run sequencer.
package ising_seq_pkg;

  localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0010_0000;
  localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_1000;
  localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0008;
  localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_000C;
  localparam logic [31:0] START_ADDR       = 32'h0000_0000;

  localparam logic [31:0] START_CODE = 32'h0000_0010;
  localparam logic [31:0] RESET_CODE = 32'h0000_0100;

  typedef enum logic [3:0] {
    IDLE,
    CFG_CUT,
    CFG_MAX,
    EDGE_WAIT,
    EDGE_WR0,
    EDGE_WR1,
    RB_ADDR,
    RB_CHK,
    RUN_RST,
    RUN_GO,
    SETTLE,
    RD_ADDR,
    RD_WAIT,
    ACCUM,
    VOTE,
    DONE
  } seq_state_t;

  // Row index lands in bits [..:2], column index in bits [..:13].
  function automatic logic [31:0] weight_addr(input logic [31:0] i, input logic [31:0] j);
    return WEIGHT_ADDR_BASE + (i << 2) + (j << 13);
  endfunction

endpackage

// File: rtl/ising_seq_vote.sv
// N saturating per-spin vote counters plus the final majority compare (ties resolve to 1).
module ising_seq_vote
  import ising_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int RUN_W = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] idx,
  input  logic [RUN_W-1:0] runs,
  output logic [N-1:0]     spins
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cnt
      logic [RUN_W:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (inc && (idx == IDX_W'(gi)) && (cnt != '1)) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign spins[gi] = ({cnt, 1'b0} >= {2'b00, runs});
    end
  endgenerate

endmodule

// File: rtl/ising_run_sequencer.sv
// Programs ising_axi from a command + edge stream, runs it RUNS times and majority-votes the phases.
// Optional weight readback after each edge pair: define ISING_SEQ_READBACK_EN.
module ising_run_sequencer
  import ising_seq_pkg::*;
#(
  parameter int N             = 8,
  parameter int WEIGHT_W      = 3,
  parameter int RUN_W         = 4,
  parameter int SETTLE_CYCLES = 100,
  parameter int READ_LAT      = 1,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             axi_rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_cutoff,
  input  logic [31:0]      cmd_max,
  input  logic [RUN_W-1:0] cmd_runs,
  input  logic             edge_valid,
  output logic             edge_ready,
  input  logic [IDX_W-1:0] edge_i,
  input  logic [IDX_W-1:0] edge_j,
  input  logic [31:0]      edge_w,
  input  logic             edge_last,
  output logic             wready,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wdata,
  output logic [31:0]      araddr,
  input  logic [31:0]      rdata,
  output logic             busy,
  output logic             res_valid,
  output logic [N-1:0]     res_spins,
  output logic             err_idx,
  output logic             err_readback
);

`ifdef ISING_SEQ_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  seq_state_t       state;
  logic [31:0]      cutoff_reg;
  logic [31:0]      max_reg;
  logic [RUN_W-1:0] runs_reg;
  logic [RUN_W-1:0] run_idx;
  logic [IDX_W-1:0] spin_idx;
  logic [IDX_W-1:0] e_i;
  logic [IDX_W-1:0] e_j;
  logic [31:0]      e_w;
  logic             e_last;
  logic [31:0]      settle_cnt;
  logic [7:0]       lat_cnt;
  logic             hit_reg;
  logic             edge_bad;
  logic             vote_clr;
  logic             vote_inc;
  logic [N-1:0]     vote_spins;

  // Phase slots are stored in reverse spin order.
  function automatic logic [31:0] phase_addr(input logic [IDX_W-1:0] s);
    return PHASE_ADDR_BASE + ((32'(N - 1) - 32'(s)) << 2);
  endfunction

  assign edge_bad = (edge_i == edge_j) || (32'(edge_i) >= 32'(N)) || (32'(edge_j) >= 32'(N));
  assign vote_clr = (state == IDLE) && cmd_valid;
  assign vote_inc = (state == ACCUM) && hit_reg;

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      edge_ready   <= 1'b0;
      wready       <= 1'b0;
      wr_addr      <= '0;
      wdata        <= '0;
      araddr       <= '0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_spins    <= '0;
      err_idx      <= 1'b0;
      err_readback <= 1'b0;
      cutoff_reg   <= '0;
      max_reg      <= '0;
      runs_reg     <= '0;
      run_idx      <= '0;
      spin_idx     <= '0;
      e_i          <= '0;
      e_j          <= '0;
      e_w          <= '0;
      e_last       <= 1'b0;
      settle_cnt   <= '0;
      lat_cnt      <= '0;
      hit_reg      <= 1'b0;
    end else begin
      wready    <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cutoff_reg   <= cmd_cutoff;
            max_reg      <= cmd_max;
            runs_reg     <= (cmd_runs == '0) ? RUN_W'(1) : cmd_runs;
            run_idx      <= '0;
            spin_idx     <= '0;
            err_idx      <= 1'b0;
            err_readback <= 1'b0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            wready       <= 1'b1;
            wr_addr      <= CTR_CUTOFF_ADDR;
            wdata        <= cmd_cutoff;
            state        <= CFG_CUT;
          end
        end
        CFG_CUT: begin
          wready  <= 1'b1;
          wr_addr <= CTR_MAX_ADDR;
          wdata   <= max_reg;
          state   <= CFG_MAX;
        end
        CFG_MAX: begin
          edge_ready <= 1'b1;
          state      <= EDGE_WAIT;
        end
        EDGE_WAIT: begin
          if (edge_valid) begin
            e_i    <= edge_i;
            e_j    <= edge_j;
            e_w    <= edge_w;
            e_last <= edge_last;
            if (edge_bad) begin
              err_idx <= 1'b1;
              if (edge_last) begin
                edge_ready <= 1'b0;
                wready     <= 1'b1;
                wr_addr    <= START_ADDR;
                wdata      <= RESET_CODE;
                state      <= RUN_RST;
              end
            end else begin
              edge_ready <= 1'b0;
              wready     <= 1'b1;
              wr_addr    <= weight_addr(32'(edge_i), 32'(edge_j));
              wdata      <= edge_w;
              state      <= EDGE_WR0;
            end
          end
        end
        EDGE_WR0: begin
          wready  <= 1'b1;
          wr_addr <= weight_addr(32'(e_j), 32'(e_i));
          wdata   <= e_w;
          state   <= EDGE_WR1;
        end
        EDGE_WR1, RB_CHK: begin
          if ((state == EDGE_WR1) && RB_EN) begin
            araddr <= weight_addr(32'(e_i), 32'(e_j));
            state  <= RB_ADDR;
          end else if ((state == RB_CHK) && (lat_cnt != 8'(READ_LAT - 1))) begin
            lat_cnt <= lat_cnt + 8'd1;
          end else begin
            if ((state == RB_CHK) && (rdata[WEIGHT_W-1:0] != e_w[WEIGHT_W-1:0])) begin
              err_readback <= 1'b1;
            end
            if (e_last) begin
              wready  <= 1'b1;
              wr_addr <= START_ADDR;
              wdata   <= RESET_CODE;
              state   <= RUN_RST;
            end else begin
              edge_ready <= 1'b1;
              state      <= EDGE_WAIT;
            end
          end
        end
        RB_ADDR: begin
          lat_cnt <= '0;
          state   <= RB_CHK;
        end
        RUN_RST: begin
          wready  <= 1'b1;
          wr_addr <= START_ADDR;
          wdata   <= START_CODE;
          state   <= RUN_GO;
        end
        RUN_GO: begin
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 32'(SETTLE_CYCLES - 1)) begin
            spin_idx <= '0;
            araddr   <= phase_addr('0);
            state    <= RD_ADDR;
          end else begin
            settle_cnt <= settle_cnt + 32'd1;
          end
        end
        RD_ADDR: begin
          lat_cnt <= '0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_cnt == 8'(READ_LAT - 1)) begin
            hit_reg <= (rdata >= cutoff_reg);
            state   <= ACCUM;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        ACCUM: begin
          if (spin_idx != IDX_W'(N - 1)) begin
            spin_idx <= spin_idx + IDX_W'(1);
            araddr   <= phase_addr(spin_idx + IDX_W'(1));
            state    <= RD_ADDR;
          end else if (run_idx != (runs_reg - RUN_W'(1))) begin
            run_idx <= run_idx + RUN_W'(1);
            wready  <= 1'b1;
            wr_addr <= START_ADDR;
            wdata   <= RESET_CODE;
            state   <= RUN_RST;
          end else begin
            state <= VOTE;
          end
        end
        VOTE: begin
          res_spins <= vote_spins;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ising_seq_vote #(
    .N     (N),
    .RUN_W (RUN_W)
  ) u_vote (
    .clk   (clk),
    .rst_n (axi_rstn),
    .clr   (vote_clr),
    .inc   (vote_inc),
    .idx   (spin_idx),
    .runs  (runs_reg),
    .spins (vote_spins)
  );

endmodule

// File: tb/tb_ising_run_sequencer.sv
// Directed bench for ising_run_sequencer with a registered-read phase/weight model of ising_axi.
module tb_ising_run_sequencer;

  localparam int N     = 8;
  localparam int RUN_W = 4;
  localparam int IDX_W = 3;

  localparam logic [31:0] WB      = 32'h0010_0000;
  localparam logic [31:0] PB      = 32'h0000_1000;
  localparam logic [31:0] A_CUT   = 32'h0000_0008;
  localparam logic [31:0] A_MAX   = 32'h0000_000C;
  localparam logic [31:0] A_START = 32'h0000_0000;
  localparam logic [31:0] C_START = 32'h0000_0010;
  localparam logic [31:0] C_RESET = 32'h0000_0100;

`ifdef ISING_SEQ_READBACK_EN
  localparam logic RB_EXP = 1'b1;
`else
  localparam logic RB_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             axi_rstn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_cutoff = '0;
  logic [31:0]      cmd_max = '0;
  logic [RUN_W-1:0] cmd_runs = '0;
  logic             edge_valid = 1'b0;
  logic             edge_ready;
  logic [IDX_W-1:0] edge_i = '0;
  logic [IDX_W-1:0] edge_j = '0;
  logic [31:0]      edge_w = '0;
  logic             edge_last = 1'b0;
  logic             wready;
  logic [31:0]      wr_addr;
  logic [31:0]      wdata;
  logic [31:0]      araddr;
  logic [31:0]      rdata = '0;
  logic             busy;
  logic             res_valid;
  logic [N-1:0]     res_spins;
  logic             err_idx;
  logic             err_readback;

  ising_run_sequencer dut (
    .clk          (clk),
    .axi_rstn     (axi_rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_cutoff   (cmd_cutoff),
    .cmd_max      (cmd_max),
    .cmd_runs     (cmd_runs),
    .edge_valid   (edge_valid),
    .edge_ready   (edge_ready),
    .edge_i       (edge_i),
    .edge_j       (edge_j),
    .edge_w       (edge_w),
    .edge_last    (edge_last),
    .wready       (wready),
    .wr_addr      (wr_addr),
    .wdata        (wdata),
    .araddr       (araddr),
    .rdata        (rdata),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_spins    (res_spins),
    .err_idx      (err_idx),
    .err_readback (err_readback)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  i;
    logic [3:0]  j;
    logic [31:0] w;
    logic        last;
  } edge_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_t;

  typedef struct packed {
    logic [31:0]           cutoff;
    logic [3:0]            runs;
    logic [2:0][7:0][7:0]  ph;
    logic [7:0]            exp_spins;
    logic [3:0]            exp_go;
  } vec_t;

  int                   checks = 0;
  int                   errors = 0;
  int                   go_cnt = 0;
  int                   rb_reads = 0;
  logic [31:0]          cyc = '0;
  logic [2:0][7:0][7:0] cur_ph = '0;
  wr_t                  wq[$];
  edge_t                edge_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic edge_t mk_edge(input int i, input int j, input int w, input bit last);
    edge_t e;
    e.i = 4'(i);
    e.j = 4'(j);
    e.w = 32'(w);
    e.last = last;
    return e;
  endfunction

  // Registered-read model: weights read back as 2, phases come from the current run's table row.
  function automatic logic [31:0] model(input logic [31:0] a);
    int slot;
    int r;
    if (a >= WB) return 32'd2;
    if (a >= PB && a < PB + 32'd32) begin
      slot = int'((a - PB) >> 2);
      r = (go_cnt < 1) ? 0 : ((go_cnt > 3) ? 2 : go_cnt - 1);
      return {24'd0, cur_ph[r][7 - slot]};
    end
    return 32'd0;
  endfunction

  always @(posedge clk) rdata <= model(araddr);

  always @(negedge clk) begin
    cyc <= cyc + 32'd1;
    if (wready) begin
      wq.push_back('{addr: wr_addr, data: wdata, cyc: cyc});
      if (wr_addr == A_START && wdata == C_START) go_cnt++;
    end
    if (busy && araddr >= WB && araddr < WB + 32'h0001_0000) rb_reads++;
  end

  task automatic send_cmd(input logic [31:0] cutoff, input logic [31:0] mx, input logic [3:0] runs);
    int t;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    wq.delete();
    go_cnt = 0;
    rb_reads = 0;
    cmd_cutoff = cutoff;
    cmd_max = mx;
    cmd_runs = runs;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_edges();
    int t;
    foreach (edge_q[k]) begin
      t = 0;
      while (!edge_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!edge_ready) begin
        chk("edge_ready_wait", 32'(edge_ready), 32'd1);
        return;
      end
      edge_i = edge_q[k].i[IDX_W-1:0];
      edge_j = edge_q[k].j[IDX_W-1:0];
      edge_w = edge_q[k].w;
      edge_last = edge_q[k].last;
      edge_valid = 1'b1;
      @(negedge clk);
      edge_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!res_valid && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    $display("job %s: spins=0x%02h go=%0d writes=%0d err_idx=%0b err_rb=%0b",
             tag, res_spins, go_cnt, wq.size(), err_idx, err_readback);
  endtask

  function automatic int weight_writes();
    int n;
    n = 0;
    foreach (wq[k]) if (wq[k].addr >= WB) n++;
    return n;
  endfunction

  function automatic int writes_through_go();
    foreach (wq[k]) if (wq[k].addr == A_START && wq[k].data == C_START) return k + 1;
    return -1;
  endfunction

  initial begin
    vec_t vecs[6];
    int t;

    vecs[0] = '{cutoff: 32'd4, runs: 4'd3, ph: '0, exp_spins: 8'h04, exp_go: 4'd3};
    vecs[0].ph[0][2] = 8'd6; vecs[0].ph[1][2] = 8'd2; vecs[0].ph[2][2] = 8'd6;
    vecs[1] = '{cutoff: 32'd4, runs: 4'd2, ph: '0, exp_spins: 8'h04, exp_go: 4'd2};
    vecs[1].ph[0][2] = 8'd6; vecs[1].ph[1][2] = 8'd2;
    vecs[2] = '{cutoff: 32'd4, runs: 4'd0, ph: '0, exp_spins: 8'h20, exp_go: 4'd1};
    vecs[2].ph[0][5] = 8'd9;
    vecs[3] = '{cutoff: 32'd4, runs: 4'd3, ph: '0, exp_spins: 8'h50, exp_go: 4'd3};
    vecs[3].ph[0][1] = 8'd6; vecs[3].ph[1][1] = 8'd2; vecs[3].ph[2][1] = 8'd2;
    vecs[3].ph[0][4] = 8'd4; vecs[3].ph[1][4] = 8'd4; vecs[3].ph[2][4] = 8'd4;
    vecs[3].ph[0][6] = 8'd2; vecs[3].ph[1][6] = 8'd5; vecs[3].ph[2][6] = 8'd5;
    vecs[4] = '{cutoff: 32'd0, runs: 4'd1, ph: '0, exp_spins: 8'hFF, exp_go: 4'd1};
    vecs[5] = '{cutoff: 32'h100, runs: 4'd1, ph: '0, exp_spins: 8'h00, exp_go: 4'd1};
    vecs[5].ph[0][3] = 8'hFF;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_edge_ready", 32'(edge_ready), 32'd0);
    chk("rst_res_spins", 32'(res_spins), 32'd0);
    axi_rstn = 1'b1;
    @(negedge clk);

    // Write-port sequence for a single edge
    cur_ph = '0;
    edge_q.delete();
    edge_q.push_back(mk_edge(0, 1, 5, 1'b1));
    send_cmd(32'd7, 32'd9, 4'd1);
    send_edges();
    wait_done("write");
    chk("wr_count", 32'(wq.size()), 32'd6);
    chk("wr0_addr", wq[0].addr, A_CUT);
    chk("wr0_data", wq[0].data, 32'd7);
    chk("wr1_addr", wq[1].addr, A_MAX);
    chk("wr1_data", wq[1].data, 32'd9);
    chk("wr2_addr", wq[2].addr, WB + 32'h2000);
    chk("wr2_data", wq[2].data, 32'd5);
    chk("wr3_addr", wq[3].addr, WB + 32'h4);
    chk("wr3_data", wq[3].data, 32'd5);
    chk("wr3_consecutive", wq[3].cyc - wq[2].cyc, 32'd1);
    chk("wr4_reset", wq[4].data, C_RESET);
    chk("wr5_start", wq[5].data, C_START);
    chk("write_spins", 32'(res_spins), 32'd0);
    chk("write_err_rb", 32'(err_readback), 32'(RB_EXP));

    // Max-cut problem: 5 nodes plus field cell 7
    edge_q.delete();
    edge_q.push_back(mk_edge(0, 1, 0, 1'b0));
    edge_q.push_back(mk_edge(0, 4, 0, 1'b0));
    edge_q.push_back(mk_edge(1, 2, 0, 1'b0));
    edge_q.push_back(mk_edge(1, 3, 0, 1'b0));
    edge_q.push_back(mk_edge(2, 3, 0, 1'b0));
    edge_q.push_back(mk_edge(3, 4, 0, 1'b0));
    for (int s = 0; s < 5; s++) edge_q.push_back(mk_edge(s, 7, 3, s == 4));
    cur_ph = '0;
    for (int s = 0; s < 8; s++) cur_ph[0][s] = 8'd1;
    cur_ph[0][0] = 8'd5; cur_ph[0][2] = 8'd5; cur_ph[0][3] = 8'd5; cur_ph[0][7] = 8'd5;
    send_cmd(32'd4, 32'd8, 4'd1);
    send_edges();
    wait_done("maxcut");
    chk("maxcut_spins", 32'(res_spins), 32'h8D);
    chk("maxcut_writes_to_go", 32'(writes_through_go()), 32'd26);
    chk("maxcut_err_idx", 32'(err_idx), 32'd0);
    chk("maxcut_err_rb", 32'(err_readback), 32'(RB_EXP));
`ifdef ISING_SEQ_READBACK_EN
    chk("maxcut_rb_reads_seen", 32'(rb_reads > 0), 32'd1);
`else
    chk("maxcut_no_rb_reads", 32'(rb_reads), 32'd0);
`endif

    // Vote table
    edge_q.delete();
    edge_q.push_back(mk_edge(0, 1, 0, 1'b1));
    for (int v = 0; v < 6; v++) begin
      cur_ph = vecs[v].ph;
      send_cmd(vecs[v].cutoff, 32'd8, vecs[v].runs);
      send_edges();
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_spins", v), 32'(res_spins), 32'(vecs[v].exp_spins));
      chk($sformatf("vec%0d_go", v), 32'(go_cnt), 32'(vecs[v].exp_go));
    end

    // Bad edges: (3,3) and (9,1) are dropped, (2,4) is programmed
    cur_ph = '0;
    edge_q.delete();
    edge_q.push_back(mk_edge(3, 3, 1, 1'b0));
    edge_q.push_back(mk_edge(9, 1, 2, 1'b0));
    edge_q.push_back(mk_edge(2, 4, 3, 1'b1));
    send_cmd(32'd4, 32'd8, 4'd1);
    send_edges();
    wait_done("bad");
    chk("bad_weight_writes", 32'(weight_writes()), 32'd2);
    chk("bad_err_idx", 32'(err_idx), 32'd1);

    // Accept clears err_idx; a bad last edge still ends programming
    edge_q.delete();
    edge_q.push_back(mk_edge(5, 5, 0, 1'b1));
    send_cmd(32'd4, 32'd8, 4'd1);
    chk("accept_clears_err_idx", 32'(err_idx), 32'd0);
    chk("accept_busy", 32'(busy), 32'd1);
    send_edges();
    wait_done("badlast");
    chk("badlast_weight_writes", 32'(weight_writes()), 32'd0);
    chk("badlast_err_idx", 32'(err_idx), 32'd1);
    chk("badlast_go", 32'(go_cnt), 32'd1);

    // Asynchronous reset in the middle of SETTLE
    edge_q.delete();
    edge_q.push_back(mk_edge(0, 1, 0, 1'b1));
    send_cmd(32'd4, 32'd8, 4'd2);
    send_edges();
    t = 0;
    while (go_cnt < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("settle_reached", 32'(go_cnt), 32'd1);
    repeat (10) @(negedge clk);
    #2 axi_rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wready", 32'(wready), 32'd0);
    chk("arst_araddr", araddr, 32'd0);
    chk("arst_wr_addr", wr_addr, 32'd0);
    chk("arst_res_spins", 32'(res_spins), 32'd0);
    chk("arst_err_idx", 32'(err_idx), 32'd0);
    repeat (2) @(negedge clk);
    axi_rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    cur_ph = '0;
    cur_ph[0][7] = 8'd9;
    send_cmd(32'd4, 32'd8, 4'd1);
    send_edges();
    wait_done("after_rst");
    chk("after_rst_spins", 32'(res_spins), 32'h80);
    chk("after_rst_writes", 32'(wq.size()), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ising_run_sequencer.md
Name: ising_run_sequencer

Overview:
- Hardware replacement for the bench-driven program/run/readout flow of ising_axi.
- Accepts a problem as a command plus an edge stream, then:
  - programs the counters and the symmetric weight pairs over ising_axi's simple write port;
  - runs the array RUNS times, issuing a reset and a start on each run;
  - reads all N phases after each run and majority-votes them into a spin vector.
- Sits between a host FIFO or DMA and ising_axi, with the same N.

Parameters:
- N, 8, spin count including the local-field cell; IDX_W = clog2(N).
- WEIGHT_W, 3, significant low bits of a weight word, used for readback compare.
- RUN_W, 4, width of the run count.
- SETTLE_CYCLES, 100, clk cycles to wait after the start write before readout.
- READ_LAT, 1, cycles from araddr change to valid rdata.

Ports:
- clk  in  1  clock
- axi_rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command handshake
- cmd_ready  out  1  high only in IDLE
- cmd_cutoff  in  32  CTR_CUTOFF value; also the spin threshold
- cmd_max  in  32  CTR_MAX value
- cmd_runs  in  RUN_W  number of runs; 0 is treated as 1
- edge_valid  in  1  edge handshake
- edge_ready  out  1  high only in EDGE_WAIT
- edge_i, edge_j  in  IDX_W each  edge endpoints
- edge_w  in  32  weight word
- edge_last  in  1  marks the final edge
- wready  out  1  write strobe to ising_axi
- wr_addr  out  32  write address
- wdata  out  32  write data
- araddr  out  32  read address
- rdata  in  32  read data
- busy  out  1  high in any state other than IDLE
- res_valid  out  1  one-cycle pulse when the result is ready
- res_spins  out  N  voted spins, bit s is spin s; held until the next command
- err_idx  out  1  sticky bad-edge flag; cleared on command accept
- err_readback  out  1  sticky readback-mismatch flag; cleared on command accept

Behaviour:
- Reset: state IDLE; every output is 0 except cmd_ready = 1; all vote counters are 0.
- Reset is asynchronous and abandons any operation, including mid-write. Partial programming inside the array is not undone.
- State flow: IDLE -> CFG_CUT -> CFG_MAX -> EDGE_WAIT -> (EDGE_WR0 -> EDGE_WR1 [-> RB_ADDR -> RB_CHK]) -> RUN_RST -> RUN_GO -> SETTLE -> RD_ADDR -> RD_WAIT -> ACCUM -> (next spin | next run | VOTE) -> DONE -> IDLE.
- Every write state lasts exactly 1 cycle: wready = 1 with wr_addr and wdata valid. wready = 0 in all other states.
- Write states:
  - CFG_CUT writes CTR_CUTOFF_ADDR.
  - CFG_MAX writes CTR_MAX_ADDR.
  - EDGE_WR0 writes WEIGHT_ADDR_BASE + (i<<2) + (j<<13).
  - EDGE_WR1 writes WEIGHT_ADDR_BASE + (j<<2) + (i<<13).
  - RUN_RST writes START_ADDR with RESET_CODE.
  - RUN_GO writes START_ADDR with START_CODE.
- Edge capture:
  - An edge is captured in EDGE_WAIT on edge_valid & edge_ready.
  - If i == j, or either index >= N: no write, err_idx is set, and edge_last is still honoured.
  - After a captured edge that has edge_last = 1, the flow goes to RUN_RST.
- SETTLE counts exactly SETTLE_CYCLES cycles; the counter starts after RUN_GO.
- Readout:
  - Spin s is read at PHASE_ADDR_BASE + ((N-1-s)<<2); phase slots are stored reversed.
  - araddr is presented in RD_ADDR; rdata is sampled READ_LAT cycles later.
  - A phase >= cutoff is a vote for 1.
  - Vote counters are RUN_W+1 bits and saturate.
- VOTE: spin = 1 iff 2*votes >= runs, so a tie resolves to 1. res_spins is updated and res_valid pulses in DONE.
- cmd_valid while busy is ignored; it is not queued.
- edge_valid outside EDGE_WAIT is not consumed.

Optional Feature:
- Macro: ISING_SEQ_READBACK_EN.
- Defined:
  - After EDGE_WR1, read address (i,j) and compare rdata[WEIGHT_W-1:0] with edge_w[WEIGHT_W-1:0].
  - A mismatch sets err_readback. Programming continues.
- Undefined: the RB states are absent, edge throughput is 2 writes per edge, and err_readback = 0.

Decomposition:
- Package ising_seq_pkg holds:
  - the address constants WEIGHT_ADDR_BASE, PHASE_ADDR_BASE, CTR_CUTOFF_ADDR, CTR_MAX_ADDR, START_ADDR;
  - START_CODE = 32'h10 and RESET_CODE = 32'h100;
  - the state enum;
  - the weight-address function (i,j) -> addr.
- Sub-module ising_seq_vote holds the N saturating vote counters plus the final majority compare.

Test Plan:
- Max-cut: 5 nodes plus field cell 7; AB, AE, BC, BD, CD, DE edges with w = 0; field edges w = 3; cutoff 4, max 8, runs 1 -> res_spins A = C = D = H = 1, B = E = 0; exactly 26 wready pulses before RUN_GO.
- Write check: edge (0,1,w = 5) -> wr_addr 0x...2000+0x0 then 0x...0004; both with wdata 5 on consecutive cycles.
- Bad edges (3,3) and (9,1) with N = 8 -> no writes for them, err_idx = 1, sequence completes, err_idx clears on the next cmd accept.
- Voting: bench-model rdata gives spin 2 phases {6,2,6} over runs = 3 -> bit 2 = 1; phases {6,2} over runs = 2 -> tie -> 1; cmd_runs = 0 -> exactly one RUN_GO.
- Reset: assert axi_rstn low during SETTLE -> outputs 0 the same cycle, cmd_ready = 1 after release, and a new command completes normally.
- With ISING_SEQ_READBACK_EN: rdata model returns 2 for edge w = 0 -> err_readback = 1; without the macro -> no read cycles during edge programming.
